// File: rtl/route_dispatch_if.sv
// route_dispatch_if: upstream flit handshake plus the five routed output links.
// master = flit source / link sink side, slave = the dispatch stage.
interface route_dispatch_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_core;
    logic [1:0]   in_dir;
    logic [4:0]   out_valid;
    logic [4:0]   out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_core, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_core, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/route_dispatch.sv
// route_dispatch: FIFO-buffered dispatch of routed flits to core/N/E/S/W.
// Optional statistics counters are built when ROUTE_DISPATCH_STATS_EN is defined.
module route_dispatch #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    route_dispatch_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    input  logic [2:0]                   stat_sel,
    output logic [CW-1:0]                stat_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_data [DEPTH];
    logic [2:0]    mem_dest [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic          has_head;
    logic          head_ready;
    logic          push;
    logic          pop;
    logic [2:0]    in_dest;
    logic [2:0]    head_dest;
    logic [4:0]    head_oh;

    // Destination index 4 is the local core; 0..3 are N,E,S,W.
    assign in_dest    = bus.in_core ? 3'd4 : {1'b0, bus.in_dir};
    assign head_dest  = mem_dest[rd_ptr];
    assign head_oh    = 5'b00001 << head_dest;
    assign has_head   = (count != '0);
    assign head_ready = |(head_oh & bus.out_ready);

    // No pass-through when full: a same-cycle pop does not free a slot.
    assign bus.in_ready  = !RESET && (count != OW'(DEPTH));
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = has_head && head_ready;
    assign bus.out_valid = has_head ? head_oh : 5'b00000;
    assign bus.out_data  = has_head ? mem_data[rd_ptr] : '0;
    assign occupancy     = count;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observable while counted as valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.in_data;
            mem_dest[wr_ptr] <= in_dest;
        end
    end

`ifdef ROUTE_DISPATCH_STATS_EN
    logic [CW-1:0] cnt [6];

    // Saturating per-output dispatch counters plus a head-stall counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < 6; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (pop && head_oh[k] && (cnt[k] != '1))
                    cnt[k] <= cnt[k] + 1'b1;
            end
            if (has_head && !head_ready && (cnt[5] != '1))
                cnt[5] <= cnt[5] + 1'b1;
        end
    end

    // Counter read mux; selects 6 and 7 read as zero.
    always_comb begin
        stat_count = '0;
        case (stat_sel)
            3'd0:    stat_count = cnt[0];
            3'd1:    stat_count = cnt[1];
            3'd2:    stat_count = cnt[2];
            3'd3:    stat_count = cnt[3];
            3'd4:    stat_count = cnt[4];
            3'd5:    stat_count = cnt[5];
            default: stat_count = '0;
        endcase
    end
`else
    wire unused_stat_sel = ^stat_sel;

    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_route_dispatch.sv
// tb_route_dispatch: random and directed traffic against a queue-based
// reference model of the dispatch stage, plus a CW=2 saturation instance.
module tb_route_dispatch;
    localparam int W      = 16;
    localparam int DEPTH  = 4;
    localparam int CW     = 16;
    localparam int OW     = $clog2(DEPTH + 1);
    localparam int SATMAX = (1 << CW) - 1;
`ifdef ROUTE_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
    } flit_t;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [OW-1:0] occupancy;
    logic [2:0]    stat_sel;
    logic [CW-1:0] stat_count;
    logic [OW-1:0] s_occ;
    logic [2:0]    s_sel;
    logic [1:0]    s_cnt;

    route_dispatch_if #(.W(W)) bus ();
    route_dispatch_if #(.W(W)) sbus ();

    route_dispatch #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus.slave),
        .occupancy(occupancy), .stat_sel(stat_sel), .stat_count(stat_count)
    );

    route_dispatch #(.W(W), .DEPTH(DEPTH), .CW(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .bus(sbus.slave),
        .occupancy(s_occ), .stat_sel(s_sel), .stat_count(s_cnt)
    );

    always #5 CLK = ~CLK;

    flit_t       q[$];
    logic [15:0] obs[$];
    int          pops[5];
    int          stalls;
    int          total = 0;
    int          bad = 0;
    int          dut_max_occ;
    bit          last_acc;
    bit          pend;
    logic [18:0] pend_flit;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int stat_exp(logic [2:0] sel);
        if (!STATS) return 0;
        if (sel < 3'd5) return pops[sel];
        if (sel == 3'd5) return stalls;
        return 0;
    endfunction

    task automatic check_outputs();
        logic [4:0]  ev;
        logic [15:0] ed;
        ev = '0;
        ed = '0;
        if (q.size() != 0) begin
            ev[q[0].dest] = 1'b1;
            ed = q[0].data;
        end
        chk("out_valid", bus.out_valid, ev);
        chk("out_data", bus.out_data, ed);
        chk("occupancy", occupancy, q.size());
        chk("in_ready", bus.in_ready, (!RESET && q.size() < DEPTH));
        chk("stat_count", stat_count, stat_exp(stat_sel));
        if (occupancy > dut_max_occ) dut_max_occ = occupancy;
    endtask

    // One clock: log observed pops, advance the model, then check outputs.
    task automatic tick();
        bit   acc;
        bit   pp;
        int   d;
        #1;
        if (|(bus.out_valid & bus.out_ready)) obs.push_back(bus.out_data);
        @(posedge CLK);
        if (pend) begin
            chk("hold_valid", bus.in_valid, 1);
            chk("hold_flit", {bus.in_core, bus.in_dir, bus.in_data}, pend_flit);
        end
        if (RESET) begin
            q.delete();
            foreach (pops[k]) pops[k] = 0;
            stalls = 0;
            pend = 0;
            last_acc = 0;
        end else begin
            acc = bus.in_valid && (q.size() < DEPTH);
            pp = 0;
            if (q.size() != 0) begin
                d = q[0].dest;
                pp = bus.out_ready[d];
                if (!pp && stalls < SATMAX) stalls++;
            end
            if (pp) begin
                if (pops[d] < SATMAX) pops[d]++;
                void'(q.pop_front());
            end
            if (acc)
                q.push_back('{bus.in_core ? 3'd4 : {1'b0, bus.in_dir}, bus.in_data});
            pend = bus.in_valid && !acc;
            pend_flit = {bus.in_core, bus.in_dir, bus.in_data};
            last_acc = acc;
        end
        #1;
        check_outputs();
    endtask

    task automatic send(logic core, logic [1:0] dir, logic [15:0] d);
        bit done;
        bus.in_core = core;
        bus.in_dir = dir;
        bus.in_data = d;
        bus.in_valid = 1'b1;
        done = 0;
        for (int n = 0; n < 64; n++) begin
            if (!done) begin
                tick();
                done = last_acc;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit done;
        stalls = 0;
        foreach (pops[k]) pops[k] = 0;
        pend = 0;
        last_acc = 0;
        dut_max_occ = 0;
        stat_sel = 3'd0;
        s_sel = 3'd0;
        bus.in_valid = 1'b1;
        bus.in_core = 1'b0;
        bus.in_dir = 2'd0;
        bus.in_data = 16'hdead;
        bus.out_ready = 5'b00000;
        sbus.in_valid = 1'b0;
        sbus.in_core = 1'b0;
        sbus.in_dir = 2'd0;
        sbus.in_data = '0;
        sbus.out_ready = 5'b11111;

        // reset held with in_valid high
        repeat (3) tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occ", occupancy, 0);
        bus.in_valid = 1'b0;
        RESET = 1'b0;
        #1;
        chk("rst_release_ready", bus.in_ready, 1);

        // routing decode
        bus.out_ready = 5'b11111;
        send(1'b0, 2'd1, 16'h0011);
        chk("dec_e_valid", bus.out_valid, 5'b00010);
        chk("dec_e_data", bus.out_data, 16'h0011);
        send(1'b1, 2'd2, 16'h0022);
        chk("dec_core_valid", bus.out_valid, 5'b10000);
        chk("dec_core_data", bus.out_data, 16'h0022);
        idle(1);
        chk("dec_empty", occupancy, 0);

        // full FIFO, fifth flit held
        bus.out_ready = 5'b00000;
        for (int i = 1; i <= 4; i++)
            send(i == 4, 2'(i), 16'(i));
        chk("full_occ", occupancy, 4);
        chk("full_ready", bus.in_ready, 0);
        bus.in_core = 1'b0;
        bus.in_dir = 2'd3;
        bus.in_data = 16'h0005;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        chk("full_held_occ", occupancy, 4);
        obs.delete();
        bus.out_ready = 5'b11111;
        done = 0;
        for (int n = 0; n < 20; n++) begin
            if (!done) begin
                tick();
                done = last_acc;
            end
        end
        if (!done) chk("full_accept_timeout", 0, 1);
        idle(6);
        chk("full_drain_cnt", obs.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < obs.size()) chk("full_order", obs[i], 16'(i + 1));

        // head-of-line blocking
        bus.out_ready = 5'b11110;
        send(1'b0, 2'd0, 16'ha0a0);
        send(1'b0, 2'd1, 16'hb0b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hol_data", bus.out_data, 16'ha0a0);
            chk("hol_valid", bus.out_valid, 5'b00001);
        end
        bus.out_ready = 5'b11111;
        tick();
        chk("hol_next_valid", bus.out_valid, 5'b00010);
        chk("hol_next_data", bus.out_data, 16'hb0b0);
        tick();
        chk("hol_empty", occupancy, 0);

        // pointer wrap at full rate
        obs.delete();
        dut_max_occ = 0;
        for (int i = 0; i < 20; i++)
            send(i[0], 2'(i >> 1), 16'(16'h0100 + i));
        idle(2);
        chk("wrap_cnt", obs.size(), 20);
        for (int i = 0; i < 20; i++)
            if (i < obs.size()) chk("wrap_order", obs[i], 16'(16'h0100 + i));
        chk("wrap_max_occ", dut_max_occ, 1);

        // statistics
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 2'd2, 16'(16'h0200 + i));
        for (int i = 0; i < 2; i++) send(1'b1, 2'd0, 16'(16'h0300 + i));
        idle(2);
        bus.out_ready = 5'b00000;
        send(1'b0, 2'd0, 16'h0400);
        idle(7);
        bus.out_ready = 5'b11111;
        idle(1);
        stat_sel = 3'd2;
        #1;
        chk("stat_s", stat_count, STATS ? 3 : 0);
        stat_sel = 3'd4;
        #1;
        chk("stat_core", stat_count, STATS ? 2 : 0);
        stat_sel = 3'd5;
        #1;
        chk("stat_stall", stat_count, STATS ? 7 : 0);
        stat_sel = 3'd6;
        #1;
        chk("stat_sel6", stat_count, 0);

        // randomized traffic with occasional mid-stream reset
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = 5'($urandom);
            stat_sel = 3'($urandom);
            if (!bus.in_valid || last_acc) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.in_core = 1'($urandom);
                bus.in_dir = 2'($urandom);
                bus.in_data = 16'($urandom);
            end
            if ($urandom_range(0, 99) == 0) RESET = 1'b1;
            tick();
            RESET = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 5'b11111;
        idle(DEPTH + 1);
        chk("rand_drain", occupancy, 0);

        // saturation with CW=2
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sbus.in_data = 16'(i);
            sbus.in_valid = 1'b1;
            @(posedge CLK);
            #1;
        end
        sbus.in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("sat_occ", s_occ, 0);
        s_sel = 3'd0;
        #1;
        chk("sat_n", s_cnt, STATS ? 3 : 0);
        s_sel = 3'd5;
        #1;
        chk("sat_stall", s_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/route_dispatch.md
Name: route_dispatch

Overview:
- Synchronous stage directly downstream of the position-check stage.
- Accepts a flit together with that stage's routing decision: core_contr (1 bit) and router_contr (2 bits).
- Buffers flits in a small FIFO and presents the head flit to exactly one of five output ports: local core, N, E, S, W.
- Sits between the position checker's cosim wrapper and the router's output links; head-of-line ordering is preserved.

Parameters:
- W, 16, flit data width in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 16, width of each statistics counter (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream flit valid.
- in_ready  out  1  stage can accept a flit.
- in_data  in  W  flit payload.
- in_core  in  1  core_contr from position check; 1 = deliver to local core.
- in_dir  in  2  router_contr from position check; 0=N, 1=E, 2=S, 3=W.
- out_valid  out  5  one-hot valid per output; bit4=core, bits3..0 = W,S,E,N.
- out_ready  in  5  per-output ready, same bit order as out_valid.
- out_data  out  W  head flit payload, shared by all outputs.
- occupancy  out  $clog2(DEPTH+1)  number of valid FIFO entries.
- stat_sel  in  3  statistics counter select: 0..4 = per-output dispatch count, 5 = stall count.
- stat_count  out  CW  selected statistics counter value.

Behaviour:
- Reset (asynchronous, while RESET=1): read/write pointers=0, occupancy=0, out_valid=0, in_ready=0, out_data=0, all statistics counters=0. RESET deasserted → in_ready=1 from the next settled cycle.
- Reset mid-operation: all buffered flits are discarded; no partial dispatch survives.
- Entry format: {core, dir, data}. The destination index is computed at push:
  - core=1 → dest=4 (local); in_dir is ignored.
  - core=0 → dest=in_dir.
- Push: in_valid && in_ready at a rising edge writes the entry at wr_ptr; wr_ptr increments and wraps mod DEPTH.
- in_ready = (occupancy != DEPTH). No pass-through when full, even if a pop occurs in the same cycle.
- Head presentation:
  - out_valid[k] = (occupancy != 0) && (head.dest == k); at most one bit is set.
  - out_data = head.data when occupancy != 0, else 0.
  - All three are combinational from FIFO state.
- Pop: out_valid[k] && out_ready[k] at a rising edge; rd_ptr increments and wraps.
- Ready on non-selected outputs is ignored.
- Latency: a flit pushed at edge N is presented at the outputs after edge N if the FIFO was empty. Minimum in-to-out latency is 1 cycle.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Throughput: 1 flit/cycle when the selected output is continuously ready.
- Backpressure: head stays presented, with stable data, until popped; later flits wait behind it (head-of-line blocking).
- Upstream protocol rule: in_data, in_core and in_dir must be held stable while in_valid=1 and in_ready=0.
- Upstream protocol rule: in_valid may not drop before acceptance.
- Violation of either upstream rule is flagged by the bench; the stage itself has no error checking.

Optional Feature:
- Macro: ROUTE_DISPATCH_STATS_EN.
- Defined:
  - Five CW-bit counters, each incrementing on a pop to its output.
  - One CW-bit stall counter, incrementing on each cycle where occupancy != 0 and out_ready[head.dest]=0.
  - All six counters saturate at 2^CW-1 and clear only on RESET.
  - stat_count = counter[stat_sel]; stat_sel values 6 and 7 read 0.
- Not defined: no counters are built; stat_count is constant 0; stat_sel is unused.

Test Plan:
- Reset check: hold RESET=1 with in_valid=1 → in_ready=0, out_valid=0, occupancy=0. Release RESET → in_ready=1.
- Routing decode: push data 0x0011 (core=0, dir=1), then 0x0022 (core=1, dir=2), all out_ready=1 →
  - out_valid=5'b00010, out_data=0x0011;
  - next cycle out_valid=5'b10000, out_data=0x0022;
  - occupancy returns to 0.
- Full FIFO: out_ready=0, push 4 flits 0x1..0x4 → occupancy=4, in_ready=0. A fifth flit 0x5 is held and not accepted. Raise out_ready=5'b11111 → outputs 0x1,0x2,0x3,0x4,0x5 in order.
- Head-of-line blocking: head dest=N with out_ready[0]=0, next entry dest=E with out_ready[1]=1 → E is not served; out_data stays stable for 10 cycles. Raise out_ready[0] → N is popped, E follows on the next cycle.
- Pointer wrap: stream 20 flits with incrementing data at in_valid=1 and all out_ready=1 → 20 pops in order, no loss or duplication, occupancy never exceeds 1.
- Stats (ROUTE_DISPATCH_STATS_EN): 3 flits to S, 2 to core, and 7 stall cycles → stat_sel=2 reads 3, 4 reads 2, 5 reads 7, 6 reads 0. With CW=2, 5 pops to N → stat_sel=0 reads 3 (saturated).
